// File: rtl/mg33_ramp_ctrl_pkg.sv
// Shared MG33 definitions: sequencer state encoding, default ramp timing and logic levels.
package mg33_ramp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_STOP = 2'd2,
    ST_DEAD = 2'd3
  } mg33_state_e;

  localparam int unsigned DUTY_MAX_DEF      = 50000;
  localparam int unsigned RAMP_STEP_DEF     = 500;
  localparam int unsigned STEP_INTERVAL_DEF = 50000;
  localparam int unsigned DEAD_TIME_DEF     = 500000;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

endpackage

// File: rtl/mg33_ramp_ctrl_tick_gen.sv
// Interval counter: one-cycle tick after every interval_p enabled cycles; clear
// forces the count back to zero and suppresses the tick.
module mg33_tick_gen #(
  parameter int unsigned interval_p = 4
) (
  input  logic Clk_i,
  input  logic Reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CW = (interval_p > 1) ? $clog2(interval_p) : 1;
  localparam logic [CW-1:0] LAST = CW'(interval_p - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/mg33_ramp_ctrl.sv
// MG33 speed-ramp / direction sequencer: slews the duty command toward an accepted
// target and sequences reversals as ramp-down, dead time, ramp-up.
module mg33_ramp_ctrl
  import mg33_ramp_ctrl_pkg::*;
#(
  parameter int unsigned duty_width_p    = 16,
  parameter int unsigned duty_max_p      = DUTY_MAX_DEF,
  parameter int unsigned ramp_step_p     = RAMP_STEP_DEF,
  parameter int unsigned step_interval_p = STEP_INTERVAL_DEF,
  parameter int unsigned dead_time_p     = DEAD_TIME_DEF
) (
  input  logic                    Clk_i,
  input  logic                    Reset_i,
  input  logic                    Req_i,
  input  logic [duty_width_p-1:0] Target_i,
  input  logic                    Dir_i,
  input  logic                    Stop_i,
  output logic                    Ack_o,
  output logic [duty_width_p-1:0] Duty_o,
  output logic                    Dir_o,
  output logic                    Busy_o,
  output mg33_state_e             State_o
);

  localparam int unsigned W = duty_width_p;
  localparam logic [W-1:0] DUTY_MAX = W'(duty_max_p);
  localparam logic [W:0]   STEP     = (W+1)'(ramp_step_p);

  // Command handshake: Req_i is held by the requester until Ack_o; it is only
  // sampled in IDLE, and Ack_o pulses in the cycle after the accepting edge.

  mg33_state_e    state_q;
  logic [W-1:0]   duty_q, tgt_q, duty_next, tgt_clamped;
  logic           dir_q, dir_t_q, ack_q, busy_q;
  logic           step_tick, dead_tick;

  // One step from cur toward goal, computed one bit wider so it can neither
  // wrap below zero nor overshoot the goal.
  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                               input logic [W-1:0] goal);
    logic [W:0] cur_x, goal_x, up, dn;
    cur_x  = {1'b0, cur};
    goal_x = {1'b0, goal};
    up     = cur_x + STEP;
    dn     = cur_x - STEP;
    if (cur_x < goal_x) begin
      return (up > goal_x) ? goal : up[W-1:0];
    end else if (dn[W] || (dn < goal_x)) begin
      return goal;
    end else begin
      return dn[W-1:0];
    end
  endfunction

  assign tgt_clamped = (Target_i > DUTY_MAX) ? DUTY_MAX : Target_i;
  assign duty_next   = step_toward(duty_q, (state_q == ST_STOP) ? '0 : tgt_q);

  mg33_tick_gen #(.interval_p(step_interval_p)) u_step_tmr (
    .Clk_i    (Clk_i),
    .Reset_i  (Reset_i),
    .clear_i  (!((state_q == ST_RAMP) || (state_q == ST_STOP))),
    .enable_i (HIGH),
    .tick_o   (step_tick)
  );

  // Dead time only counts once the emergency stop is released.
  mg33_tick_gen #(.interval_p(dead_time_p)) u_dead_tmr (
    .Clk_i    (Clk_i),
    .Reset_i  (Reset_i),
    .clear_i  ((state_q != ST_DEAD) || Stop_i),
    .enable_i (HIGH),
    .tick_o   (dead_tick)
  );

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      dir_q   <= HIGH;
      dir_t_q <= HIGH;
      ack_q   <= LOW;
      busy_q  <= LOW;
    end else begin
      ack_q <= LOW;
      if (Stop_i) begin
        duty_q  <= '0;
        tgt_q   <= '0;
        state_q <= ST_DEAD;
        busy_q  <= HIGH;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (Req_i) begin
              tgt_q   <= tgt_clamped;
              dir_t_q <= Dir_i;
              ack_q   <= HIGH;
              busy_q  <= HIGH;
              if ((Dir_i == dir_q) || (duty_q == '0)) begin
                state_q <= ST_RAMP;
                if (duty_q == '0) dir_q <= Dir_i;
              end else begin
                state_q <= ST_STOP;
              end
            end
          end
          ST_RAMP: begin
            if (duty_q == tgt_q) begin
              state_q <= ST_IDLE;
              busy_q  <= LOW;
            end else if (step_tick) begin
              duty_q <= duty_next;
              if (duty_next == tgt_q) begin
                state_q <= ST_IDLE;
                busy_q  <= LOW;
              end
            end
          end
          ST_STOP: begin
            if (duty_q == '0) begin
              state_q <= ST_DEAD;
            end else if (step_tick) begin
              duty_q <= duty_next;
              if (duty_next == '0) state_q <= ST_DEAD;
            end
          end
          ST_DEAD: begin
            if (dead_tick) begin
              if (tgt_q == '0) begin
                state_q <= ST_IDLE;
                busy_q  <= LOW;
              end else begin
                dir_q   <= dir_t_q;
                state_q <= ST_RAMP;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= LOW;
          end
        endcase
      end
    end
  end

  assign Ack_o   = ack_q;
  assign Duty_o  = duty_q;
  assign Dir_o   = dir_q;
  assign Busy_o  = busy_q;
  assign State_o = state_q;

endmodule

// File: tb/tb_mg33_ramp_ctrl.sv
// Bench for mg33_ramp_ctrl: directed and random commands checked cycle by cycle
// against a trace derived from the ramp/reversal rules, plus stop and reset cases.
`timescale 1ns/1ps
module tb_mg33_ramp_ctrl;
  import mg33_ramp_ctrl_pkg::*;

  localparam int DW   = 16;
  localparam int MAX  = 100;
  localparam int S    = 30;
  localparam int N    = 4;
  localparam int D    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req, dir_in, stop;
  logic [DW-1:0] target;
  logic          ack, dir_out, busy;
  logic [DW-1:0] duty;
  mg33_state_e   st;

  int n_vec = 0;
  int n_err = 0;
  int m_duty;
  logic m_dir;
  logic prev_dir;
  logic [DW+1:0] exp_q[$];

  mg33_ramp_ctrl #(
    .duty_width_p(DW), .duty_max_p(MAX), .ramp_step_p(S),
    .step_interval_p(N), .dead_time_p(D)
  ) dut (
    .Clk_i(clk), .Reset_i(rst_n), .Req_i(req), .Target_i(target), .Dir_i(dir_in),
    .Stop_i(stop), .Ack_o(ack), .Duty_o(duty), .Dir_o(dir_out), .Busy_o(busy),
    .State_o(st)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input int b, input logic d, input int v);
    exp_q.push_back({b[0], d, DW'(v)});
  endfunction

  // Reference: build the expected per-cycle {busy,dir,duty} trace for one command.
  function automatic void build_trace(input int t_raw, input logic dir_t,
                                      output int t_out, output logic dir_out_m);
    int t, cur;
    logic dc;
    t = (t_raw > MAX) ? MAX : t_raw;
    cur = m_duty;
    exp_q.delete();
    if (dir_t == m_dir || cur == 0) begin
      dc = dir_t;
      if (cur == t) push(1, dc, cur);
    end else begin
      dc = m_dir;
      while (cur != 0) begin
        repeat (N) push(1, dc, cur);
        cur = (cur > S) ? cur - S : 0;
      end
      repeat (D) push(1, dc, 0);
      dc = dir_t;
    end
    while (cur != t) begin
      repeat (N) push(1, dc, cur);
      if (cur < t) cur = (cur + S > t) ? t : cur + S;
      else         cur = (cur - S < t) ? t : cur - S;
    end
    push(0, dc, t);
    t_out = t;
    dir_out_m = dc;
  endfunction

  task automatic run_cmd(input int t_raw, input logic dir_t, input bit noise);
    logic [DW+1:0] e;
    int t;
    logic dc;
    bit first;
    build_trace(t_raw, dir_t, t, dc);
    req = 1'b1; target = DW'(t_raw); dir_in = dir_t;
    first = 1'b1;
    while (exp_q.size() > 0) begin
      step_clk();
      e = exp_q.pop_front();
      check("duty", duty, e[DW-1:0]);
      check("dir", dir_out, e[DW]);
      check("busy", busy, e[DW+1]);
      check("ack", ack, first);
      check("duty_le_max", duty <= DW'(MAX), 1);
      if (dir_out !== prev_dir) check("dir_flip_at_zero", duty, 0);
      prev_dir = dir_out;
      first = 1'b0;
      if (noise && exp_q.size() > 0) begin
        req = 1'($urandom_range(0, 1));
        target = DW'($urandom_range(0, 300));
        dir_in = 1'($urandom_range(0, 1));
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
    m_duty = t;
    m_dir = dc;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step_clk();
      check("idle_duty", duty, m_duty);
      check("idle_dir", dir_out, m_dir);
      check("idle_busy", busy, 0);
      check("idle_ack", ack, 0);
      prev_dir = dir_out;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_duty", duty, 0);
    check("rst_dir", dir_out, 1);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_state", st, ST_IDLE);
    step_clk();
    rst_n = 1'b1;
    m_duty = 0; m_dir = 1'b1; prev_dir = 1'b1;
  endtask

  // Launches a ramp from zero and stops at the first sample showing duty 60.
  task automatic ramp_to_60(input logic d);
    bit found;
    found = 1'b0;
    req = 1'b1; target = DW'(100); dir_in = d;
    step_clk();
    req = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (duty == DW'(60)) found = 1'b1;
      else step_clk();
    end
    check("reach_60", duty, 60);
  endtask

  initial begin
    rst_n = 1'b1; req = 1'b0; target = '0; dir_in = 1'b1; stop = 1'b0;
    m_duty = 0; m_dir = 1'b1; prev_dir = 1'b1;
    step_clk();
    do_reset();
    idle_cycles(2);

    run_cmd(70, 1'b1, 1'b0);
    idle_cycles(1);
    run_cmd(250, 1'b1, 1'b0);
    run_cmd(70, 1'b1, 1'b1);
    run_cmd(40, 1'b0, 1'b0);
    idle_cycles(1);
    run_cmd(40, 1'b0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      run_cmd($urandom_range(1, 250), 1'($urandom_range(0, 1)), 1'b1);
      idle_cycles($urandom_range(0, 2));
    end

    // Asynchronous reset mid-ramp, reverse direction so Dir_o must be restored.
    do_reset();
    ramp_to_60(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_duty", duty, 0);
    check("async_rst_dir", dir_out, 1);
    check("async_rst_busy", busy, 0);
    step_clk();
    rst_n = 1'b1;
    m_duty = 0; m_dir = 1'b1; prev_dir = 1'b1;
    step_clk();

    // Emergency stop mid-ramp, held 20 cycles, then dead time back to IDLE.
    ramp_to_60(1'b1);
    stop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step_clk();
      check("stop_duty", duty, 0);
      check("stop_dir", dir_out, 1);
      check("stop_busy", busy, 1);
      check("stop_ack", ack, 0);
    end
    stop = 1'b0;
    for (int i = 0; i < D - 1; i++) begin
      step_clk();
      check("dead_duty", duty, 0);
      check("dead_busy", busy, 1);
    end
    step_clk();
    check("post_stop_busy", busy, 0);
    check("post_stop_duty", duty, 0);
    check("post_stop_dir", dir_out, 1);
    m_duty = 0; m_dir = 1'b1; prev_dir = 1'b1;
    run_cmd(50, 1'b0, 1'b0);

    // Stop and Req together in IDLE: stop wins, no acknowledge.
    req = 1'b1; target = DW'(90); dir_in = 1'b0; stop = 1'b1;
    step_clk();
    req = 1'b0; stop = 1'b0;
    check("stopreq_ack", ack, 0);
    check("stopreq_duty", duty, 0);
    check("stopreq_dir", dir_out, 0);
    check("stopreq_busy", busy, 1);
    for (int i = 0; i < D - 1; i++) begin
      step_clk();
      check("stopreq_ack_dead", ack, 0);
    end
    step_clk();
    check("stopreq_idle", busy, 0);
    check("stopreq_end_duty", duty, 0);
    m_duty = 0; m_dir = 1'b0; prev_dir = 1'b0;
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
